// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM burst front end.
package sram_pkg;

    localparam int SRAM_ADDR_WIDTH = 6;
    localparam int SRAM_DATA_WIDTH = 8;
    localparam int SRAM_DEPTH      = 64;
    localparam int RD_BUF_DEPTH    = 2;
    localparam int RD_CNT_W        = $clog2(RD_BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

endpackage

// File: rtl/rd_out_fifo.sv
// Two-entry read-return buffer; head entry is presented combinationally.
module rd_out_fifo
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [RD_CNT_W-1:0]   count_o
);

    logic [DATA_WIDTH-1:0] mem_q [RD_BUF_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [RD_CNT_W-1:0]   count_q;
    logic                  pop_ok;

    // A pop on an empty buffer is ignored so the count can never wrap.
    assign pop_ok  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + RD_CNT_W'(push_i) - RD_CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst command front end: streams write beats into the SRAM and returns
// read beats through a small buffer with full backpressure.
module sram_burst_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int DEPTH      = SRAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [ADDR_WIDTH-1:0] cur_addr_d;
    logic [ADDR_WIDTH-1:0] beats_left_q;
    logic [ADDR_WIDTH-1:0] beats_left_d;
    logic                  inflight_q;

    logic [RD_CNT_W-1:0]   buf_count;
    logic [DATA_WIDTH-1:0] buf_head;
    logic                  buf_nonempty;
    logic                  wr_beat;
    logic                  pop;
    logic                  issue;
    logic                  last_beat;

    assign buf_nonempty = (buf_count != '0);

    // Handshake outputs are forced low while rst is held, whatever the state.
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign wr_ready  = (state_q == ST_WRITE) && !rst;
    assign rd_valid  = buf_nonempty && !rst;
    assign rd_data   = buf_head;
    assign busy      = !rst && ((state_q != ST_IDLE) || inflight_q || buf_nonempty);

    assign wr_beat   = wr_valid && wr_ready;
    assign pop       = rd_valid && rd_ready;
    // Occupancy after this cycle, counting the word already in the SRAM pipe,
    // must stay below the buffer depth for another read to be issued.
    assign issue     = (state_q == ST_READ) && !rst &&
                       ((int'(buf_count) + int'(inflight_q)) < (RD_BUF_DEPTH + int'(pop)));

    assign sram_we   = wr_beat;
    assign sram_addr = cur_addr_q;
    assign sram_data = wr_beat ? wr_data : '0;

    assign last_beat    = (beats_left_q == '0);
    assign cur_addr_d   = (cur_addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : cur_addr_q + 1'b1;
    assign beats_left_d = beats_left_q - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            inflight_q <= issue;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cur_addr_q   <= cmd_addr;
                        beats_left_q <= cmd_len;
                        state_q      <= cmd_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (wr_beat) begin
                        cur_addr_q   <= cur_addr_d;
                        beats_left_q <= beats_left_d;
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        cur_addr_q   <= cur_addr_d;
                        beats_left_q <= beats_left_d;
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    rd_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (sram_rdata),
        .pop_i       (pop),
        .head_o      (buf_head),
        .count_o     (buf_count)
    );

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl with a behavioural single-port SRAM.
module tb_sram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_write, wr_valid, rd_ready;
    logic [5:0] cmd_addr, cmd_len;
    logic [7:0] wr_data;
    logic       cmd_ready, wr_ready, rd_valid, busy, sram_we;
    logic [7:0] rd_data, sram_data, sram_rdata;
    logic [5:0] sram_addr;

    logic [7:0] mem [64];
    logic       preload;

    logic [7:0] wbuf [64];
    bit         pbuf [16];
    int         plen;
    logic [7:0] rbuf [64];

    int   n_pass = 0, n_total = 0;
    int   w_beats, w_last, r_got, r_first, r_last;
    bit   w_ok, r_ok, r_unstable, r_valid_stall;
    logic [5:0] r_addr_stall;
    logic [7:0] r_data_stall;

    always #5 clk = ~clk;

    sram_burst_ctrl dut (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr (cmd_addr), .cmd_len (cmd_len),
        .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_data (wr_data),
        .rd_valid (rd_valid), .rd_ready (rd_ready), .rd_data (rd_data),
        .busy (busy), .sram_we (sram_we), .sram_addr (sram_addr),
        .sram_data (sram_data), .sram_rdata (sram_rdata)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(8'h80 + i);
        end else if (sram_we) begin
            mem[sram_addr] <= sram_data;
        end
        sram_rdata <= mem[sram_addr];
    end

    task automatic send_cmd(input logic w, input logic [5:0] a, input logic [5:0] l, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
            #1;
            if (cmd_ready) ok = 1'b1;
        end
        if (ok) @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drive_write(input logic [5:0] a, input logic [5:0] l);
        send_cmd(1'b1, a, l, w_ok);
        w_beats = 0; w_last = 0;
        for (int k = 1; w_ok && w_beats < int'(l) + 1 && k <= 300; k++) begin
            @(negedge clk);
            wr_valid = (k <= plen) ? pbuf[k-1] : 1'b1;
            wr_data  = wbuf[w_beats];
            #1;
            if (wr_valid && wr_ready) begin w_beats++; w_last = k; end
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic drive_read(input logic [5:0] a, input logic [5:0] l, input int stall);
        bit         prev_hold = 1'b0;
        logic [7:0] prev_data = '0;
        send_cmd(1'b0, a, l, r_ok);
        r_got = 0; r_first = 0; r_last = 0; r_unstable = 1'b0;
        for (int k = 1; r_ok && r_got < int'(l) + 1 && k <= 300; k++) begin
            @(negedge clk);
            rd_ready = (k > stall);
            #1;
            if (rd_valid && r_first == 0) r_first = k;
            if (k == stall) begin
                r_addr_stall = sram_addr; r_valid_stall = rd_valid; r_data_stall = rd_data;
            end
            if (prev_hold && rd_data !== prev_data) r_unstable = 1'b1;
            prev_hold = rd_valid && !rd_ready;
            prev_data = rd_data;
            if (rd_valid && rd_ready) begin rbuf[r_got] = rd_data; r_got++; r_last = k; end
        end
        @(posedge clk);
        #1 rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; preload = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0; plen = 0;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); else n_pass++;
        n_total++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); else n_pass++;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (sram_we !== 1'b0) $display("FAIL reset_sram_we: got %b expected 0", sram_we); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL post_reset_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
        $display("reset: cmd_ready=%b busy=%b", cmd_ready, busy);
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'hA0 + i);
        plen = 0;
        drive_write(6'd5, 6'd3);
        $display("write addr=5 len=3 beats=%0d last_cycle=%0d", w_beats, w_last);
        n_total++; if (w_beats !== 4) $display("FAIL wr_beats: got %0d expected 4", w_beats); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL wr_busy_after: got %b expected 0", busy); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (mem[5+i] !== 8'(8'hA0 + i)) $display("FAIL wr_mem[%0d]: got %h expected %h", 5+i, mem[5+i], 8'(8'hA0 + i));
            else n_pass++;
        end
        drive_read(6'd5, 6'd3, 0);
        $display("read addr=5 len=3 got=%0d first=%0d last=%0d", r_got, r_first, r_last);
        n_total++; if (r_first !== 3) $display("FAIL rd_latency: got %0d expected 3", r_first); else n_pass++;
        n_total++; if (r_last !== 6) $display("FAIL rd_throughput_last: got %0d expected 6", r_last); else n_pass++;
        n_total++; if (r_got !== 4) $display("FAIL rd_count: got %0d expected 4", r_got); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (rbuf[i] !== 8'(8'hA0 + i)) $display("FAIL rd_data[%0d]: got %h expected %h", i, rbuf[i], 8'(8'hA0 + i));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        send_cmd(1'b1, 6'd50, 6'd0, ok);
        @(negedge clk);
        wr_valid = 1'b1; wr_data = 8'h77;
        #1;
        n_total++; if (cmd_ready !== 1'b0) $display("FAIL b2b_cmd_ready_in_write: got %b expected 0", cmd_ready); else n_pass++;
        n_total++; if (sram_we !== 1'b1) $display("FAIL b2b_sram_we: got %b expected 1", sram_we); else n_pass++;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_idle_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
        drive_read(6'd50, 6'd0, 0);
        $display("b2b write/read addr=50 got=%0d data=%h", r_got, rbuf[0]);
        n_total++; if (r_got !== 1 || rbuf[0] !== 8'h77) $display("FAIL b2b_readback: got %0d beats data %h expected 1 beat 77", r_got, rbuf[0]); else n_pass++;
    endtask

    task automatic test_backpressure();
        drive_read(6'd5, 6'd3, 6);
        $display("backpressure read got=%0d first=%0d last=%0d addr_at_stall=%0d", r_got, r_first, r_last, r_addr_stall);
        n_total++; if (r_addr_stall !== 6'd7) $display("FAIL bp_issues: got addr %0d expected 7", r_addr_stall); else n_pass++;
        n_total++; if (r_valid_stall !== 1'b1 || r_data_stall !== 8'hA0) $display("FAIL bp_hold: got valid %b data %h expected 1 A0", r_valid_stall, r_data_stall); else n_pass++;
        n_total++; if (r_unstable !== 1'b0) $display("FAIL bp_stable: got unstable %b expected 0", r_unstable); else n_pass++;
        n_total++; if (r_last !== 10) $display("FAIL bp_last: got %0d expected 10", r_last); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (rbuf[i] !== 8'(8'hA0 + i)) $display("FAIL bp_data[%0d]: got %h expected %h", i, rbuf[i], 8'(8'hA0 + i));
            else n_pass++;
        end
        @(negedge clk);
        n_total++; if (rd_valid !== 1'b0) $display("FAIL bp_no_extra: got rd_valid %b expected 0", rd_valid); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'h11 + i);
        plen = 0;
        drive_write(6'd62, 6'd3);
        $display("wrap write addr=62 beats=%0d", w_beats);
        n_total++; if (mem[62] !== 8'h11) $display("FAIL wrap_mem62: got %h expected 11", mem[62]); else n_pass++;
        n_total++; if (mem[63] !== 8'h12) $display("FAIL wrap_mem63: got %h expected 12", mem[63]); else n_pass++;
        n_total++; if (mem[0] !== 8'h13) $display("FAIL wrap_mem0: got %h expected 13", mem[0]); else n_pass++;
        n_total++; if (mem[1] !== 8'h14) $display("FAIL wrap_mem1: got %h expected 14", mem[1]); else n_pass++;
        drive_read(6'd62, 6'd3, 0);
        n_total++;
        if (r_got !== 4 || rbuf[0] !== 8'h11 || rbuf[1] !== 8'h12 || rbuf[2] !== 8'h13 || rbuf[3] !== 8'h14)
            $display("FAIL wrap_readback: got %0d beats %h %h %h %h expected 4 beats 11 12 13 14", r_got, rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
        else n_pass++;
    endtask

    task automatic test_write_gaps();
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) pbuf[i] = pat[i];
        plen = 7;
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'h51 + i);
        drive_write(6'd30, 6'd3);
        plen = 0;
        $display("gapped write addr=30 beats=%0d last_cycle=%0d", w_beats, w_last);
        n_total++; if (w_last !== 7) $display("FAIL gap_last_beat: got %0d expected 7", w_last); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL gap_busy_fall: got %b expected 0", busy); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (mem[30+i] !== 8'(8'h51 + i)) $display("FAIL gap_mem[%0d]: got %h expected %h", 30+i, mem[30+i], 8'(8'h51 + i));
            else n_pass++;
        end
        n_total++; if (mem[34] !== 8'hA2) $display("FAIL gap_mem34_untouched: got %h expected A2", mem[34]); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        send_cmd(1'b1, 6'd40, 6'd3, ok);
        @(negedge clk); wr_valid = 1'b1; wr_data = 8'h61;
        @(negedge clk); wr_data = 8'h62;
        @(negedge clk); wr_data = 8'h63; rst = 1'b1;
        #1;
        n_total++; if (sram_we !== 1'b0 || wr_ready !== 1'b0) $display("FAIL rstw_during: got we %b wr_ready %b expected 0 0", sram_we, wr_ready); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rstw_after: got cmd_ready %b busy %b expected 1 0", cmd_ready, busy); else n_pass++;
        n_total++;
        if (mem[40] !== 8'h61 || mem[41] !== 8'h62 || mem[42] !== 8'hAA || mem[43] !== 8'hAB)
            $display("FAIL rstw_mem: got %h %h %h %h expected 61 62 AA AB", mem[40], mem[41], mem[42], mem[43]);
        else n_pass++;
        drive_read(6'd40, 6'd3, 0);
        $display("reset mid-write readback got=%0d %h %h %h %h", r_got, rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
        n_total++;
        if (r_got !== 4 || rbuf[0] !== 8'h61 || rbuf[1] !== 8'h62 || rbuf[2] !== 8'hAA || rbuf[3] !== 8'hAB)
            $display("FAIL rstw_readback: got %0d beats %h %h %h %h expected 4 beats 61 62 AA AB", r_got, rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
        else n_pass++;
    endtask

    task automatic test_full_depth();
        int errs;
        for (int i = 0; i < 64; i++) wbuf[i] = 8'(i * 3 + 7);
        plen = 0;
        drive_write(6'd0, 6'd63);
        n_total++; if (w_beats !== 64) $display("FAIL full_wr_beats: got %0d expected 64", w_beats); else n_pass++;
        errs = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 8'(i * 3 + 7)) errs++;
        n_total++; if (errs !== 0) $display("FAIL full_mem: got %0d bad words expected 0", errs); else n_pass++;
        drive_read(6'd0, 6'd63, 0);
        errs = 0;
        for (int i = 0; i < 64; i++) if (rbuf[i] !== 8'(i * 3 + 7)) errs++;
        $display("full depth read got=%0d bad=%0d last=%0d", r_got, errs, r_last);
        n_total++; if (r_got !== 64 || errs !== 0) $display("FAIL full_readback: got %0d beats %0d bad expected 64 beats 0 bad", r_got, errs); else n_pass++;
        n_total++; if (r_last !== 66) $display("FAIL full_rd_last: got %0d expected 66", r_last); else n_pass++;
        @(negedge clk);
        n_total++; if (sram_addr !== 6'd0) $display("FAIL full_cur_addr: got %0d expected 0", sram_addr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_write_gaps();
        test_reset_mid_write();
        test_full_depth();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Burst command front end for the single-port SRAM. Accepts read/write burst commands over valid/ready, streams write beats into the SRAM and returns read beats through a 2-entry output buffer with full backpressure support. It sits directly upstream of the SRAM and is the only block that drives the SRAM's `we`, `addr` and `data` pins.

## Interface
- `ADDR_WIDTH`, default 6: SRAM address width; `DEPTH` must equal 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 8: word width.
- `DEPTH`, default 64: SRAM words.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_write` in 1: 1 means write burst, 0 means read burst.
- `cmd_addr` in ADDR_WIDTH: start address.
- `cmd_len` in ADDR_WIDTH: beats minus 1 (0 is 1 beat, 63 is 64 beats).
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in DATA_WIDTH: write-beat stream.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out DATA_WIDTH: read-beat stream.
- `busy` out 1: burst active, read in flight, or buffer non-empty.
- `sram_we` out 1, `sram_addr` out ADDR_WIDTH, `sram_data` out DATA_WIDTH: SRAM drive.
- `sram_rdata` in DATA_WIDTH: SRAM `out`.

## Operation
- **SRAM model relied on:**
  - Write at posedge when `we`=1.
  - When `we`=0, the posedge registers `addr`, and `out` shows that word during the following cycle.
- **FSM states:** IDLE, WRITE, READ. Registered: `cur_addr`, `beats_left`.
- **IDLE:**
  - `cmd_ready`=1 (0 while `rst` is high).
  - On `cmd_valid` & `cmd_ready`: load `cur_addr`=`cmd_addr`, `beats_left`=`cmd_len`, then go to WRITE or READ per `cmd_write`.
- **WRITE:**
  - `wr_ready`=1, and it is 0 in every other state.
  - A beat is `wr_valid` & `wr_ready`. Per beat, combinationally: `sram_we`=1, `sram_addr`=`cur_addr`, `sram_data`=`wr_data`.
  - Only accepted beats advance `cur_addr` (+1 mod DEPTH) and decrement `beats_left`.
  - When the beat with `beats_left`=0 is accepted, go to IDLE.
- **READ:**
  - `sram_we`=0 and `sram_addr`=`cur_addr`.
  - Issue condition: `count + inflight - pop < 2`, where `count` is buffer occupancy, `inflight` is 1 if a read was issued last cycle, and `pop` is `rd_valid` & `rd_ready`.
  - Each issue advances `cur_addr` and `beats_left`. After the last issue, go to IDLE; the buffer drains independently.
  - The in-flight word is pushed into the buffer at the next posedge from `sram_rdata`.
- **Outside WRITE:** `sram_we`=0. `sram_addr` holds `cur_addr` and `sram_data` holds 0.
- **Output buffer:** 2-entry FIFO.
  - `rd_valid` = buffer non-empty; `rd_data` = head entry.
  - Push and pop in the same cycle are allowed.
  - Never overflows, guaranteed by the issue condition.
- **Address arithmetic:** ADDR_WIDTH-bit, wraps 63 to 0. Length counts in ADDR_WIDTH bits, so at most DEPTH beats.
- **Hazards:** no write can occur while a read is in flight, because IDLE costs at least one cycle before a WRITE beat.
- **Reset (any time, including mid-burst):**
  - State goes to IDLE; `count`=0, `inflight`=0.
  - Outputs: `rd_valid`=0, `wr_ready`=0, `sram_we`=0, `busy`=0, `cmd_ready`=0 during reset and 1 after.
  - SRAM contents are untouched; beats already written stay written.

## Timing
- **Command handshake** at edge E0.
- **Writes:** `wr_ready` is high from the cycle after E0. Throughput is 1 beat/cycle. A beat accepted at edge N is in the SRAM at N.
- **Reads:**
  - First issue in the cycle after E0; SRAM captures the address at E1; buffer captures at E2.
  - `rd_valid` rises after E2, i.e. 2 cycles after the command.
  - With `rd_ready`=1, throughput is 1 beat/cycle.
- **Back-to-back commands:** at least 1 IDLE cycle between bursts.
- **`rd_data` stability:** stable while `rd_valid` & !`rd_ready`.

## Structure
- Package `sram_pkg`:
  - state enum (`ST_IDLE`, `ST_WRITE`, `ST_READ`);
  - `ADDR_WIDTH`/`DATA_WIDTH`/`DEPTH` defaults;
  - `RD_BUF_DEPTH` = 2.
- Sub-module `rd_out_fifo`: 2-entry synchronous FIFO with push/pop/count, reset clears count. The instantiating top is the controller.

## Test plan
- **Write then read back:** write addr 5, len 3, data A0..A3 with continuous `wr_valid`; then read addr 5, len 3 with `rd_ready`=1. Required: `rd_data` A0,A1,A2,A3 on consecutive cycles, first `rd_valid` 2 cycles after the read handshake.
- **Wrap:** write addr 62, len 3, data 11..14. Required: SRAM[62]=11, [63]=12, [0]=13, [1]=14. Read-back matches.
- **Backpressure:** read 4 beats with `rd_ready`=0 for 6 cycles. Required: exactly 2 issues then stall, `rd_valid`=1 with `rd_data` stable; after release, all 4 beats arrive in order with no loss or duplication.
- **Write gaps:** `wr_valid` pattern 1,0,0,1,0,1,1 for a 4-beat write. Required: only accepted beats are written, to consecutive addresses, and `busy` falls after the 4th beat.
- **Reset mid-write:** assert `rst` after 2 of 4 beats. Required: next cycle `cmd_ready`=1, `busy`=0; read-back shows 2 new words and 2 old words.
- **Full depth:** `cmd_len`=63 write then read from addr 0. Required: all 64 words round-trip, `cur_addr` returns to 0.
